rv32imf_prefetch_ctrl: RTL
==========================

RV32IMF_PREFETCH_CTRL -- requirements
Module: rv32imf_prefetch_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2: capacity in entries of the downstream instruction FIFO; legal range 1..8.
REQ-002 SHALL have parameter MAX_OUT, default 2: maximum outstanding bus transactions; legal range 1..4.
REQ-003 SHALL have parameter RST_ADDR, default 32'h0000_0000: fetch address after reset.
REQ-004 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_i  in  1  fetch enable from the core.
REQ-007 SHALL have port branch_i  in  1  redirect strobe, one cycle.
REQ-008 SHALL have port branch_addr_i  in  32  redirect target.
REQ-009 SHALL have port trans_valid_o  out  1  bus request valid.
REQ-010 SHALL have port trans_ready_i  in  1  bus request accepted.
REQ-011 SHALL have port trans_addr_o  out  32  bus request word address.
REQ-012 SHALL have port resp_valid_i  in  1  bus read data returned; exactly one per accepted request, in order.
REQ-013 SHALL have port fifo_cnt_i  in  $clog2(DEPTH)+1 (min 2)  current FIFO occupancy.
REQ-014 SHALL have port fifo_push_o  out  1  push returned data into the FIFO.
REQ-015 SHALL have port fifo_flush_o  out  1  flush the FIFO.
REQ-016 SHALL have port busy_o  out  1  request pending or response outstanding.

Function
REQ-017 SHALL keep a 32-bit next-address register: branch_i loads {branch_addr_i[31:2],2'b00}; each handshake (trans_valid_o & trans_ready_i) of a non-stale request adds 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-018 SHALL keep an outstanding counter out_q, width $clog2(MAX_OUT+1): +1 on handshake, -1 on resp_valid_i, unchanged when both occur in the same cycle; a resp_valid_i while out_q==0 is ignored (no underflow).
REQ-019 SHALL issue only when the credit condition holds: out_q < MAX_OUT and out_q + fifo_cnt_i < DEPTH, with sums computed wide enough not to overflow.
REQ-020 SHALL implement FSM IDLE, REQ, REQ_STALE.
REQ-021 IDLE -> REQ when req_i & credit & ~branch_i; trans_addr_o = next address; trans_valid_o = 1 in REQ and REQ_STALE only.
REQ-022 REQ: trans_valid_o and trans_addr_o SHALL remain stable until handshake; on handshake -> REQ if req_i & credit (counting the new request) holds, else IDLE.
REQ-023 REQ with branch_i and no handshake -> REQ_STALE; request stays asserted at the old address; target latched into the next-address register.
REQ-024 REQ with branch_i and handshake in the same cycle: accepted request is counted as discard; -> IDLE.
REQ-025 REQ_STALE on handshake SHALL increment the discard counter and -> IDLE; a further branch_i in REQ_STALE only reloads the target.
REQ-026 SHALL keep a discard counter disc_q: on branch_i, load out_q minus 1 if resp_valid_i that cycle (floor 0); add 1 for each stale-request handshake (REQ-024, REQ-025).
REQ-027 fifo_push_o = resp_valid_i & (disc_q == 0) & ~branch_i; a resp_valid_i with disc_q > 0 SHALL decrement disc_q and not push.
REQ-028 fifo_flush_o = branch_i, combinational, same cycle.
REQ-029 busy_o = trans_valid_o | (out_q != 0).
REQ-030 req_i deassertion SHALL NOT withdraw an asserted trans_valid_o; it only blocks new issues from IDLE/REQ.
REQ-031 Simultaneous branch_i and resp_valid_i: response dropped, FIFO flushed, out_q decremented.

Reset
REQ-032 rst_i asserted at any time, including mid-transaction, SHALL immediately force FSM=IDLE, out_q=0, disc_q=0, next address=RST_ADDR; trans_valid_o=0, fifo_push_o=0, busy_o=0; fifo_flush_o follows branch_i.
REQ-033 First request after reset deassertion SHALL carry address RST_ADDR.

Verification
REQ-034 Reset, req_i=1, trans_ready_i=1, one-cycle response latency, DEPTH=2 -> addresses 0x0,0x4,0x8… ; never more than 2 outstanding; push per response.
REQ-035 fifo_cnt_i held at 2 (full) -> trans_valid_o stays 0; release to 0 -> request issued next cycle.
REQ-036 trans_ready_i=0 while REQ at 0x10, branch_i to 0x103 -> addr held 0x10 until ready; that response not pushed; next request 0x100.
REQ-037 Two outstanding, branch_i to 0x40 -> fifo_flush_o pulse, next two responses dropped, first pushed response is from 0x40.
REQ-038 Branch to 0xFFFF_FFFC -> next requests 0xFFFF_FFFC then 0x0000_0000.
REQ-039 rst_i asserted with trans_valid_o=1 and out_q=2 -> all outputs 0 same cycle; after release first address RST_ADDR.

Source files
------------

// File: rtl/rv32imf_prefetch_ctrl.sv
// rv32imf_prefetch_ctrl: instruction prefetch sequencer with FIFO-credit flow control
// and discard accounting for responses that were in flight when a branch redirected the fetch stream.
module rv32imf_prefetch_ctrl #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned MAX_OUT = 2,
  parameter logic [31:0] RST_ADDR = 32'h0000_0000,
  localparam int unsigned CW = ($clog2(DEPTH) + 1 < 2) ? 2 : $clog2(DEPTH) + 1,
  localparam int unsigned OW = $clog2(MAX_OUT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic          branch_i,
  input  logic [31:0]   branch_addr_i,
  output logic          trans_valid_o,
  input  logic          trans_ready_i,
  output logic [31:0]   trans_addr_o,
  input  logic          resp_valid_i,
  input  logic [CW-1:0] fifo_cnt_i,
  output logic          fifo_push_o,
  output logic          fifo_flush_o,
  output logic          busy_o
);
  typedef enum logic [1:0] {IDLE, REQ, REQ_STALE} state_e;
  state_e state_q, state_d;
  logic [31:0] nxt_q, nxt_d, addr_q, addr_d, used;
  logic [OW-1:0] out_q, out_d, disc_q, disc_d;
  logic hs, rsp, stale_hs, credit_now, credit_nxt;
  assign trans_valid_o = state_q != IDLE;
  assign trans_addr_o = addr_q;
  assign hs = trans_valid_o & trans_ready_i;
  assign rsp = resp_valid_i & (out_q != '0);
  assign stale_hs = hs & ((state_q == REQ_STALE) | branch_i);
  assign used = 32'(out_q) + 32'(fifo_cnt_i);
  // credit_nxt reserves room for the request being accepted right now
  assign credit_now = (32'(out_q) < MAX_OUT) && (used < DEPTH);
  assign credit_nxt = (32'(out_q) + 32'd1 < MAX_OUT) && (used + 32'd1 < DEPTH);
  assign fifo_push_o = resp_valid_i & (disc_q == '0) & ~branch_i & ~rst_i;
  assign fifo_flush_o = branch_i;
  assign busy_o = trans_valid_o | (out_q != '0);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    out_d = out_q + OW'(hs) - OW'(rsp);
    nxt_d = branch_i ? {branch_addr_i[31:2], 2'b00} : (hs && !stale_hs) ? nxt_q + 32'd4 : nxt_q;
    disc_d = (branch_i ? out_q - OW'(rsp) : disc_q - OW'(resp_valid_i && disc_q != '0)) + OW'(stale_hs);
    case (state_q)
      IDLE: if (req_i && credit_now && !branch_i) begin
        state_d = REQ;
        addr_d = nxt_q;
      end
      REQ: if (hs) begin
        state_d = (!branch_i && req_i && credit_nxt) ? REQ : IDLE;
        addr_d = nxt_q + 32'd4;
      end else if (branch_i) begin
        state_d = REQ_STALE;
      end
      REQ_STALE: state_d = hs ? IDLE : REQ_STALE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      nxt_q <= RST_ADDR;
      addr_q <= RST_ADDR;
      out_q <= '0;
      disc_q <= '0;
    end else begin
      state_q <= state_d;
      nxt_q <= nxt_d;
      addr_q <= addr_d;
      out_q <= out_d;
      disc_q <= disc_d;
    end
  end
endmodule
